// File: rtl/spi_regfile_if.sv
// rtl/spi_regfile_if.sv - SPI pin bundle between an SPI master and spi_regfile
interface spi_regfile_if;
    logic sclk_raw;
    logic mosi_raw;
    logic cs_n_raw;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk_raw,
        output mosi_raw,
        output cs_n_raw,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sclk_raw,
        input  mosi_raw,
        input  cs_n_raw,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI Mode 0 register file; define SPI_RDBACK_EN to build MISO readback
module spi_regfile #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    spi_regfile_if.slave                   spi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic                           wr_strobe,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic                           frame_err
);
    localparam int FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state_q, state_d;

    logic sclk_s1_q, sclk_s2_q, sclk_d_q;
    logic mosi_s1_q, mosi_s2_q;
    logic cs_s1_q, cs_s2_q, cs_d_q;
    logic sclk_rise_q, cs_fall_q, cs_rise_q;

    // Edge pulses are registered, adding one cycle after the two-flop synchronisers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_d_q    <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_d_q      <= 1'b1;
            sclk_rise_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= spi.sclk_raw;
            sclk_s2_q   <= sclk_s1_q;
            sclk_d_q    <= sclk_s2_q;
            mosi_s1_q   <= spi.mosi_raw;
            mosi_s2_q   <= mosi_s1_q;
            cs_s1_q     <= spi.cs_n_raw;
            cs_s2_q     <= cs_s1_q;
            cs_d_q      <= cs_s2_q;
            sclk_rise_q <= sclk_s2_q & ~sclk_d_q;
            cs_fall_q   <= ~cs_s2_q & cs_d_q;
            cs_rise_q   <= cs_s2_q & ~cs_d_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall_q) state_d = SHIFT;
            SHIFT:   if (cs_rise_q) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [FRAME_BITS-1:0] shreg_q, shreg_d, shreg_shift;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sample;

    assign sample      = (state_q == SHIFT) && sclk_rise_q;
    assign shreg_shift = {shreg_q[FRAME_BITS-2:0], mosi_s2_q};

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (cs_fall_q) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (sample) begin
            shreg_d = shreg_shift;
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    logic                  frm_rw;
    logic [ADDR_WIDTH-1:0] frm_addr;
    logic [DATA_WIDTH-1:0] frm_data;
    logic                  addr_hit;
    logic                  do_write;
    logic                  do_err;

    assign frm_rw   = shreg_q[FRAME_BITS-1];
    assign frm_addr = shreg_q[DATA_WIDTH +: ADDR_WIDTH];
    assign frm_data = shreg_q[DATA_WIDTH-1:0];

    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (frm_addr == ADDR_WIDTH'(i)) addr_hit = 1'b1;
        end
    end

    // Out-of-range writes and correct-length reads fall through silently.
    assign do_write = (state_q == COMMIT) && (cnt_q == CNT_FULL) && frm_rw && addr_hit;
    assign do_err   = (state_q == COMMIT) && (cnt_q != CNT_FULL);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  wr_strobe_q, frame_err_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= do_write;
            frame_err_q <= do_err;
            if (do_write) begin
                wr_addr_q <= frm_addr;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (frm_addr == ADDR_WIDTH'(i)) regs_q[i] <= frm_data;
                end
            end
        end
    end

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = wr_addr_q;

`ifdef SPI_RDBACK_EN
    logic                  sclk_fall_q;
    logic [DATA_WIDTH-1:0] rb_q, rb_load;
    logic [ADDR_WIDTH-1:0] rb_addr;
    logic                  rd_act_q, miso_q;

    assign rb_addr = shreg_shift[ADDR_WIDTH-1:0];

    always_comb begin
        rb_load = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rb_addr == ADDR_WIDTH'(i)) rb_load = regs_q[i];
        end
    end

    // Load on the rising edge that completes the address; shift on later falling edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_fall_q <= 1'b0;
        end else begin
            sclk_fall_q <= ~sclk_s2_q & sclk_d_q;
        end
        if (rst || state_q != SHIFT) begin
            rb_q     <= '0;
            rd_act_q <= 1'b0;
            miso_q   <= 1'b0;
        end else if (sample && cnt_q == CNT_W'(ADDR_WIDTH)) begin
            rb_q     <= rb_load;
            rd_act_q <= ~shreg_shift[ADDR_WIDTH];
        end else if (sclk_fall_q && rd_act_q) begin
            miso_q <= rb_q[DATA_WIDTH-1];
            rb_q   <= {rb_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = ~cs_s2_q;
`else
    assign spi.miso    = 1'b0;
    assign spi.miso_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_regfile.sv
// tb/tb_spi_regfile.sv - randomized self-checking bench for spi_regfile against a register-array model
module tb_spi_regfile;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int NR = 5;
    localparam int FB = 1 + AW + DW;
`ifdef SPI_RDBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_regfile_if spi();
    logic [NR*DW-1:0] regs_out;
    logic             wr_strobe;
    logic [AW-1:0]    wr_addr;
    logic             frame_err;

    spi_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi.slave),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    logic [DW-1:0] model [NR];
    int tests_run = 0;
    int tests_failed = 0;
    int strb_cnt = 0, err_cnt = 0, overlap_cnt = 0;
    bit watch77 = 1'b0, saw77 = 1'b0;
    logic [AW-1:0] strb_addr;
    logic [DW-1:0] rx;
    bit oe_seen;

    always @(negedge clk) begin
        if (wr_strobe) begin
            strb_cnt++;
            strb_addr = wr_addr;
        end
        if (frame_err) err_cnt++;
        if (wr_strobe && frame_err) overlap_cnt++;
        if (watch77 && regs_out[15:8] == 8'h77) saw77 = 1'b1;
    end

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    task automatic model_apply(input logic [31:0] bits, input int n,
                               output int e_strb, output int e_err, output logic [DW-1:0] e_rx);
        int addr;
        addr   = int'(bits[14:8]);
        e_strb = 0;
        e_err  = 0;
        e_rx   = '0;
        if (n != FB) begin
            e_err = 1;
        end else if (bits[15]) begin
            if (addr < NR) begin
                model[addr] = bits[7:0];
                e_strb = 1;
            end
        end else if (RB && addr < NR) begin
            e_rx = model[addr];
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input int gap);
        rx = '0;
        oe_seen = 1'b0;
        spi.cs_n_raw = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi.mosi_raw = bits[n-1-i];
            repeat (8) @(negedge clk);
            spi.sclk_raw = 1'b1;
            if (i >= 1 + AW && i < FB) rx = {rx[DW-2:0], spi.miso};
            oe_seen |= spi.miso_oe;
            repeat (8) @(negedge clk);
            spi.sclk_raw = 1'b0;
        end
        repeat (8) @(negedge clk);
        spi.cs_n_raw = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        tests_run++; if (regs_out !== '0) begin tests_failed++; $display("FAIL reset_regs got=%h exp=0", regs_out); end
        tests_run++; if (spi.miso_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_miso_oe got=%b exp=0", spi.miso_oe); end
        tests_run++; if (spi.miso !== 1'b0) begin tests_failed++; $display("FAIL reset_miso got=%b exp=0", spi.miso); end
        tests_run++; if (wr_strobe !== 1'b0 || frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes got=%b%b exp=00", wr_strobe, frame_err); end
        tests_run++; if (wr_addr !== '0) begin tests_failed++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    endtask

    task automatic test_write();
        int s0, e0, es, ee, lat;
        logic [DW-1:0] er;
        s0 = strb_cnt; e0 = err_cnt; lat = -1;
        model_apply(32'h84A5, FB, es, ee, er);
        send_frame(32'h84A5, FB, 0);
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (regs_out[39:32] == 8'hA5 && wr_strobe) lat = k - 1;
        end
        repeat (8) @(negedge clk);
        tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL write_latency got=%0d exp=4", lat); end
        tests_run++; if (regs_out !== model_flat()) begin tests_failed++; $display("FAIL write_regs got=%h exp=%h", regs_out, model_flat()); end
        tests_run++; if (strb_cnt - s0 != es) begin tests_failed++; $display("FAIL write_strobe_count got=%0d exp=%0d", strb_cnt - s0, es); end
        tests_run++; if (strb_addr !== 7'd4) begin tests_failed++; $display("FAIL write_wr_addr got=%0d exp=4", strb_addr); end
        tests_run++; if (err_cnt - e0 != ee) begin tests_failed++; $display("FAIL write_err_count got=%0d exp=%0d", err_cnt - e0, ee); end
    endtask

    task automatic test_readback();
        int s0, e0, es, ee;
        logic [DW-1:0] er;
        model_apply(32'h823C, FB, es, ee, er);
        send_frame(32'h823C, FB, 12);
        s0 = strb_cnt; e0 = err_cnt;
        model_apply(32'h0200, FB, es, ee, er);
        send_frame(32'h0200, FB, 12);
        tests_run++; if (rx !== er) begin tests_failed++; $display("FAIL readback_addr2 got=%h exp=%h", rx, er); end
        tests_run++; if (oe_seen !== RB) begin tests_failed++; $display("FAIL readback_miso_oe got=%b exp=%b", oe_seen, RB); end
        tests_run++; if (strb_cnt != s0 || err_cnt != e0) begin tests_failed++; $display("FAIL readback_side_effects strb=%0d err=%0d exp=0/0", strb_cnt - s0, err_cnt - e0); end
        model_apply(32'h1000, FB, es, ee, er);
        send_frame(32'h1000, FB, 12);
        tests_run++; if (rx !== er) begin tests_failed++; $display("FAIL readback_oob got=%h exp=%h", rx, er); end
        tests_run++; if (regs_out !== model_flat()) begin tests_failed++; $display("FAIL readback_regs got=%h exp=%h", regs_out, model_flat()); end
    endtask

    task automatic test_out_of_range();
        int s0, e0, es, ee;
        logic [DW-1:0] er;
        s0 = strb_cnt; e0 = err_cnt;
        model_apply(32'h90FF, FB, es, ee, er);
        send_frame(32'h90FF, FB, 12);
        tests_run++; if (regs_out !== model_flat()) begin tests_failed++; $display("FAIL oob_regs got=%h exp=%h", regs_out, model_flat()); end
        tests_run++; if (strb_cnt - s0 != es) begin tests_failed++; $display("FAIL oob_strobe got=%0d exp=%0d", strb_cnt - s0, es); end
        tests_run++; if (err_cnt - e0 != ee) begin tests_failed++; $display("FAIL oob_err got=%0d exp=%0d", err_cnt - e0, ee); end
    endtask

    task automatic test_short_long();
        int lens [3] = '{9, 17, 0};
        logic [31:0] pats [3] = '{32'h0000_0109, 32'h0001_08AA, 32'h0};
        int s0, e0, es, ee;
        logic [DW-1:0] er;
        for (int t = 0; t < 3; t++) begin
            s0 = strb_cnt; e0 = err_cnt;
            model_apply(pats[t], lens[t], es, ee, er);
            send_frame(pats[t], lens[t], 12);
            tests_run++; if (err_cnt - e0 != ee) begin tests_failed++; $display("FAIL len%0d_err got=%0d exp=%0d", lens[t], err_cnt - e0, ee); end
            tests_run++; if (strb_cnt - s0 != es) begin tests_failed++; $display("FAIL len%0d_strobe got=%0d exp=%0d", lens[t], strb_cnt - s0, es); end
            tests_run++; if (regs_out !== model_flat()) begin tests_failed++; $display("FAIL len%0d_regs got=%h exp=%h", lens[t], regs_out, model_flat()); end
        end
    endtask

    task automatic test_back_to_back();
        int s0, e0, es, ee, exp_s;
        logic [DW-1:0] er;
        logic [31:0] bits;
        s0 = strb_cnt; e0 = err_cnt; exp_s = 0;
        for (int k = 0; k < 6; k++) begin
            bits = {16'h0, 1'b1, 7'(k % NR), 8'($urandom)};
            model_apply(bits, FB, es, ee, er);
            exp_s += es;
            send_frame(bits, FB, 4);
        end
        repeat (12) @(negedge clk);
        tests_run++; if (strb_cnt - s0 != exp_s) begin tests_failed++; $display("FAIL b2b_strobes got=%0d exp=%0d", strb_cnt - s0, exp_s); end
        tests_run++; if (err_cnt != e0) begin tests_failed++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - e0); end
        tests_run++; if (regs_out !== model_flat()) begin tests_failed++; $display("FAIL b2b_regs got=%h exp=%h", regs_out, model_flat()); end
    endtask

    task automatic test_random();
        int s0, e0, es, ee, n;
        logic [DW-1:0] er;
        logic [31:0] bits;
        for (int k = 0; k < 24; k++) begin
            bits = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                n = FB;
                bits[31:16] = '0;
                bits[14:8] = 7'($urandom_range(0, 7));
            end else begin
                n = $urandom_range(0, 20);
                if (n == FB) n = FB + 2;
            end
            s0 = strb_cnt; e0 = err_cnt;
            model_apply(bits, n, es, ee, er);
            send_frame(bits, n, 12);
            tests_run++; if (strb_cnt - s0 != es || err_cnt - e0 != ee) begin tests_failed++; $display("FAIL rand%0d_pulses bits=%h n=%0d strb=%0d err=%0d exp=%0d/%0d", k, bits, n, strb_cnt - s0, err_cnt - e0, es, ee); end
            tests_run++; if (regs_out !== model_flat()) begin tests_failed++; $display("FAIL rand%0d_regs got=%h exp=%h", k, regs_out, model_flat()); end
            if (es == 1) begin
                tests_run++; if (strb_addr !== bits[14:8]) begin tests_failed++; $display("FAIL rand%0d_wr_addr got=%0d exp=%0d", k, strb_addr, bits[14:8]); end
            end
            if (n == FB) begin
                tests_run++; if (rx !== er) begin tests_failed++; $display("FAIL rand%0d_rx got=%h exp=%h", k, rx, er); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0, es, ee;
        logic [DW-1:0] er;
        logic [31:0] bits;
        bits = 32'h8177;
        spi.cs_n_raw = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            spi.mosi_raw = bits[FB-1-i];
            repeat (8) @(negedge clk);
            spi.sclk_raw = 1'b1;
            repeat (8) @(negedge clk);
            spi.sclk_raw = 1'b0;
        end
        watch77 = 1'b1;
        rst = 1'b1;
        spi.cs_n_raw = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        s0 = strb_cnt;
        tests_run++; if (regs_out !== model_flat()) begin tests_failed++; $display("FAIL midrst_regs got=%h exp=%h", regs_out, model_flat()); end
        model_apply(32'h8155, FB, es, ee, er);
        send_frame(32'h8155, FB, 12);
        watch77 = 1'b0;
        tests_run++; if (regs_out[15:8] !== 8'h55) begin tests_failed++; $display("FAIL midrst_reg1 got=%h exp=55", regs_out[15:8]); end
        tests_run++; if (regs_out !== model_flat()) begin tests_failed++; $display("FAIL midrst_all got=%h exp=%h", regs_out, model_flat()); end
        tests_run++; if (saw77 !== 1'b0) begin tests_failed++; $display("FAIL midrst_no77 got=%b exp=0", saw77); end
        tests_run++; if (strb_cnt - s0 != es) begin tests_failed++; $display("FAIL midrst_strobe got=%0d exp=%0d", strb_cnt - s0, es); end
    endtask

    task automatic test_pulses();
        tests_run++; if (overlap_cnt != 0) begin tests_failed++; $display("FAIL pulse_overlap got=%0d exp=0", overlap_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        spi.sclk_raw = 1'b0;
        spi.mosi_raw = 1'b0;
        spi.cs_n_raw = 1'b1;
        model_reset();
        test_reset();
        test_write();
        test_readback();
        test_out_of_range();
        test_short_long();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_pulses();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
